data_memory: RTL

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 133 +++++++++++++
 1 files changed

// File: rtl/data_memory.sv
// Word-organised data memory with sw/sh/sb stores, lw/lh/lhu/lb/lbu loads,
// combinational read path and alignment/range error detection.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic [1:0]  Store_Type,
  input  logic [2:0]  Load_Type,
  output logic [31:0] RD,
  output logic        Addr_Error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_index;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  size_t         w_size;
  logic          w_inRange;
  logic          w_aligned;
  logic          w_storeEn;
  logic [31:0]   w_wrData;
  logic [3:0]    w_byteEn;
  logic [31:0]   w_merged;

  assign w_index   = Addr[AW+1:2];
  assign w_word    = r_mem[w_index];
  assign w_half    = Addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte    = w_word[{Addr[1:0], 3'b000} +: 8];
  assign w_inRange = (Addr < BYTE_LIMIT);

  // Access size comes from the store encoding on writes, the load encoding otherwise.
  always_comb begin
    w_size = SZ_WORD;
    if (MemWrite) begin
      case (Store_Type)
        2'b00:   w_size = SZ_WORD;
        2'b01:   w_size = SZ_HALF;
        2'b10:   w_size = SZ_BYTE;
        default: w_size = SZ_NONE;
      endcase
    end else begin
      case (Load_Type)
        3'b001, 3'b010: w_size = SZ_HALF;
        3'b011, 3'b100: w_size = SZ_BYTE;
        default:        w_size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    case (w_size)
      SZ_WORD: w_aligned = (Addr[1:0] == 2'b00);
      SZ_HALF: w_aligned = (Addr[0] == 1'b0);
      default: w_aligned = 1'b1;
    endcase
  end

  assign Addr_Error = !w_inRange || !w_aligned;

  always_comb begin
    RD = 32'h0;
    if (!Addr_Error) begin
      case (Load_Type)
        3'b001:  RD = {{16{w_half[15]}}, w_half};
        3'b010:  RD = {16'h0, w_half};
        3'b011:  RD = {{24{w_byte[7]}}, w_byte};
        3'b100:  RD = {24'h0, w_byte};
        default: RD = w_word;
      endcase
    end
  end

  // Replicate the store lane across the word so the byte enables alone pick the target bytes.
  always_comb begin
    w_wrData = WD;
    w_byteEn = 4'b0000;
    case (Store_Type)
      2'b00: begin
        w_wrData = WD;
        w_byteEn = 4'b1111;
      end
      2'b01: begin
        w_wrData = {2{WD[15:0]}};
        w_byteEn = Addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_wrData = {4{WD[7:0]}};
        w_byteEn = 4'b0001 << Addr[1:0];
      end
      default: begin
        w_wrData = WD;
        w_byteEn = 4'b0000;
      end
    endcase
  end

  always_comb begin
    w_merged = w_word;
    for (int b = 0; b < 4; b++) begin
      if (w_byteEn[b]) w_merged[b*8 +: 8] = w_wrData[b*8 +: 8];
    end
  end

  assign w_storeEn = MemWrite && !Addr_Error && (Store_Type != 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_storeEn) begin
      r_mem[w_index] <= w_merged;
    end
  end

endmodule
